// File: rtl/tc_mem_pkg.sv
// Shared definitions for the RAM request path: request encodings, sequencer states and
// the bit layout of the packed request record {write, addr0, addr1, wdata}.
package tc_mem_pkg;

    localparam int unsigned AddrWidth = 16;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StStall = 2'd2
    } seq_state_e;

    function automatic int unsigned req_width(input int unsigned bw);
        return 1 + 2 * AddrWidth + bw;
    endfunction

    function automatic int unsigned wdata_lsb(input int unsigned bw);
        return 0 * bw;
    endfunction

    function automatic int unsigned addr1_lsb(input int unsigned bw);
        return bw;
    endfunction

    function automatic int unsigned addr0_lsb(input int unsigned bw);
        return bw + AddrWidth;
    endfunction

    function automatic int unsigned write_bit(input int unsigned bw);
        return bw + 2 * AddrWidth;
    endfunction

endpackage

// File: rtl/tc_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers, registered full/empty and a synchronous flush.
// Head data is read straight from storage so downstream logic sees registered state only.
module tc_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        do_push  = push && !full_q && !flush;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: empty_q masks stale entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/tc_ram_request_sequencer.sv
// Queues RAM read-pair/write requests and issues one per cycle to the dual-load RAM,
// capturing read data into a registered valid/ready response slot.
module tc_ram_request_sequencer
    import tc_mem_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [AddrWidth-1:0] req_addr0,
    input  logic [AddrWidth-1:0] req_addr1,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    input  logic                 flush,
    output logic                 ram_load0,
    output logic                 ram_load1,
    output logic                 ram_save,
    output logic [AddrWidth-1:0] ram_address0,
    output logic [AddrWidth-1:0] ram_address1,
    output logic [BIT_WIDTH-1:0] ram_in,
    input  logic [BIT_WIDTH-1:0] ram_out0,
    input  logic [BIT_WIDTH-1:0] ram_out1,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BIT_WIDTH-1:0] rsp_data0,
    output logic [BIT_WIDTH-1:0] rsp_data1,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic [CNT_WIDTH-1:0] wr_count,
    output seq_state_e           fsm_state
);

    localparam int unsigned ReqW     = req_width(BIT_WIDTH);
    localparam int unsigned WdataLsb = wdata_lsb(BIT_WIDTH);
    localparam int unsigned Addr1Lsb = addr1_lsb(BIT_WIDTH);
    localparam int unsigned Addr0Lsb = addr0_lsb(BIT_WIDTH);
    localparam int unsigned WriteBit = write_bit(BIT_WIDTH);

    logic [ReqW-1:0]      enq_rec, head_rec;
    logic                 fifo_full, fifo_empty;
    logic                 head_write, issue, issue_rd, issue_wr;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [BIT_WIDTH-1:0] rsp_data0_q, rsp_data0_d, rsp_data1_q, rsp_data1_d;
    logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;

    assign enq_rec = {req_write, req_addr0, req_addr1, req_wdata};

    tc_sync_fifo #(
        .WIDTH(ReqW),
        .DEPTH(FIFO_DEPTH)
    ) u_req_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .push (req_valid),
        .wdata(enq_rec),
        .pop  (issue),
        .rdata(head_rec),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign req_ready  = !fifo_full;
    assign head_write = (head_rec[WriteBit] == REQ_WRITE);

    // A read may issue into a slot that is being drained on the same edge.
    always_comb begin
        issue    = !fifo_empty && (head_write || !rsp_valid_q || rsp_ready);
        issue_wr = issue && head_write;
        issue_rd = issue && !head_write;

        ram_load0    = 1'b0;
        ram_load1    = 1'b0;
        ram_save     = 1'b0;
        ram_address0 = '0;
        ram_address1 = '0;
        ram_in       = '0;
        if (issue_wr) begin
            ram_save     = 1'b1;
            ram_address0 = head_rec[Addr0Lsb +: AddrWidth];
            ram_in       = head_rec[WdataLsb +: BIT_WIDTH];
        end else if (issue_rd) begin
            ram_load0    = 1'b1;
            ram_load1    = 1'b1;
            ram_address0 = head_rec[Addr0Lsb +: AddrWidth];
            ram_address1 = head_rec[Addr1Lsb +: AddrWidth];
        end

        fsm_state = StIssue;
        if (fifo_empty) begin
            fsm_state = StIdle;
        end else if (!issue) begin
            fsm_state = StStall;
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data0_d = rsp_data0_q;
        rsp_data1_d = rsp_data1_q;
        if (issue_rd) begin
            rsp_valid_d = 1'b1;
            rsp_data0_d = ram_out0;
            rsp_data1_d = ram_out1;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        rd_count_d = rd_count_q + CNT_WIDTH'(issue_rd);
        wr_count_d = wr_count_q + CNT_WIDTH'(issue_wr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data0_q <= '0;
            rsp_data1_q <= '0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data0_q <= rsp_data0_d;
            rsp_data1_q <= rsp_data1_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data0 = rsp_data0_q;
    assign rsp_data1 = rsp_data1_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_tc_ram_request_sequencer.sv
// Bench for tc_ram_request_sequencer: queue-based reference model checked every cycle,
// a behavioural dual-load RAM, and directed scenarios with literal expectations.
module tb_tc_ram_request_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, flush = 1'b0, rsp_ready = 1'b0;
    logic [15:0] req_addr0 = '0, req_addr1 = '0, req_wdata = '0;
    logic        req_ready, ram_load0, ram_load1, ram_save, rsp_valid;
    logic [15:0] ram_address0, ram_address1, ram_in, ram_out0, ram_out1;
    logic [15:0] rsp_data0, rsp_data1, rd_count, wr_count;
    logic [1:0]  fsm_state;

    // Narrow-counter instance for the wrap scenario
    logic        s_req_valid = 1'b0;
    logic        s_req_ready, s_load0, s_load1, s_save, s_rsp_valid;
    logic [15:0] s_addr0, s_addr1, s_in, s_rsp_data0, s_rsp_data1;
    logic [1:0]  s_rd_count, s_wr_count, s_fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tc_ram_request_sequencer #(.BIT_WIDTH(16), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata(req_wdata), .flush(flush), .ram_load0(ram_load0), .ram_load1(ram_load1),
        .ram_save(ram_save), .ram_address0(ram_address0), .ram_address1(ram_address1),
        .ram_in(ram_in), .ram_out0(ram_out0), .ram_out1(ram_out1), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
        .rd_count(rd_count), .wr_count(wr_count), .fsm_state(fsm_state)
    );

    tc_ram_request_sequencer #(.BIT_WIDTH(16), .FIFO_DEPTH(4), .CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_write(1'b1), .req_addr0(16'h0003), .req_addr1(16'h0000),
        .req_wdata(16'h1234), .flush(1'b0), .ram_load0(s_load0), .ram_load1(s_load1),
        .ram_save(s_save), .ram_address0(s_addr0), .ram_address1(s_addr1),
        .ram_in(s_in), .ram_out0(16'h0000), .ram_out1(16'h0000), .rsp_valid(s_rsp_valid),
        .rsp_ready(1'b1), .rsp_data0(s_rsp_data0), .rsp_data1(s_rsp_data1),
        .rd_count(s_rd_count), .wr_count(s_wr_count), .fsm_state(s_fsm_state)
    );

    // Behavioural RAM: combinational reads, writes committed on negedge
    logic [15:0] ram_mem [0:65535];
    assign ram_out0 = ram_mem[ram_address0];
    assign ram_out1 = ram_mem[ram_address1];
    always @(negedge clk) if (ram_save) ram_mem[ram_address0] = ram_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-order request list plus a response slot
    typedef struct packed {
        logic        w;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] d;
    } req_t;

    req_t        mq[$];
    logic [15:0] model_mem [0:65535];
    logic        m_rv;
    logic [15:0] m_d0, m_d1, m_rc, m_wc;

    function automatic logic m_issue();
        if (mq.size() == 0) return 1'b0;
        return mq[0].w || !m_rv || rsp_ready;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_rv = 1'b0; m_d0 = '0; m_d1 = '0; m_rc = '0; m_wc = '0;
        end else begin
            logic can_acc, iss;
            req_t h;
            can_acc = mq.size() < 4;
            iss = m_issue();
            if (iss) begin
                h = mq.pop_front();
                if (h.w) begin
                    model_mem[h.a0] = h.d;
                    m_wc = m_wc + 16'd1;
                end else begin
                    m_d0 = model_mem[h.a0];
                    m_d1 = model_mem[h.a1];
                    m_rc = m_rc + 16'd1;
                end
            end
            if (iss && !h.w) m_rv = 1'b1;
            else if (m_rv && rsp_ready) m_rv = 1'b0;
            if (flush) mq.delete();
            else if (req_valid && can_acc) mq.push_back({req_write, req_addr0, req_addr1, req_wdata});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic iss, hw;
            logic [15:0] ha0, ha1, hd;
            logic [1:0] st;
            iss = m_issue();
            hw = 1'b0; ha0 = '0; ha1 = '0; hd = '0;
            if (mq.size() > 0) begin
                hw = mq[0].w; ha0 = mq[0].a0; ha1 = mq[0].a1; hd = mq[0].d;
            end
            st = (mq.size() == 0) ? 2'd0 : (iss ? 2'd1 : 2'd2);
            check("req_ready", req_ready, mq.size() < 4);
            check("ram_save", ram_save, iss && hw);
            check("ram_load0", ram_load0, iss && !hw);
            check("ram_load1", ram_load1, iss && !hw);
            check("ram_address0", ram_address0, iss ? ha0 : 16'h0);
            check("ram_address1", ram_address1, (iss && !hw) ? ha1 : 16'h0);
            check("ram_in", ram_in, (iss && hw) ? hd : 16'h0);
            check("rsp_valid", rsp_valid, m_rv);
            check("rsp_data0", rsp_data0, m_d0);
            check("rsp_data1", rsp_data1, m_d1);
            check("rd_count", rd_count, m_rc);
            check("wr_count", wr_count, m_wc);
            check("fsm_state", fsm_state, st);
        end
    end

    task automatic enq(input logic w, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] d);
        req_write = w; req_addr0 = a0; req_addr1 = a1; req_wdata = d;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Waits (bounded) for a response and checks it against literals
    task automatic expect_rsp(input string name, input logic [15:0] d0, input logic [15:0] d1);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        check({name, "_arrived"}, got, 1'b1);
        check({name, "_d0"}, rsp_data0, d0);
        check({name, "_d1"}, rsp_data1, d1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram_mem[i] = '0;
            model_mem[i] = '0;
        end
        idle(2);
        rst = 1'b0;

        // Reset mid-queue with three requests pending
        enq(1'b0, 16'd5, 16'd6, 16'd0);
        enq(1'b0, 16'd6, 16'd5, 16'd0);
        enq(1'b0, 16'd7, 16'd7, 16'd0);
        enq(1'b0, 16'd8, 16'd8, 16'd0);
        @(negedge clk);
        check("pre_rst_rd_count", rd_count, 16'd1);
        check("pre_rst_stall", fsm_state, 2'd2);
        #2 rst = 1'b1;
        #1;
        check("rst_load0", ram_load0, 1'b0);
        check("rst_save", ram_save, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rd_count", rd_count, 16'd0);
        check("rst_wr_count", wr_count, 16'd0);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_fsm", fsm_state, 2'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Write then read the same address
        rsp_ready = 1'b1;
        enq(1'b1, 16'd5, 16'd0, 16'hBEEF);
        enq(1'b0, 16'd5, 16'd6, 16'd0);
        expect_rsp("wr_rd", 16'hBEEF, 16'h0000);
        check("wr_rd_rd_count", rd_count, 16'd1);
        check("wr_rd_wr_count", wr_count, 16'd1);
        idle(2);

        // Backpressure: four reads behind a held response
        enq(1'b1, 16'd7, 16'd0, 16'h1111);
        enq(1'b1, 16'd8, 16'd0, 16'h2222);
        idle(2);
        rsp_ready = 1'b0;
        enq(1'b0, 16'd5, 16'd6, 16'd0);
        enq(1'b0, 16'd7, 16'd8, 16'd0);
        enq(1'b0, 16'd8, 16'd7, 16'd0);
        enq(1'b0, 16'd6, 16'd5, 16'd0);
        repeat (2) @(negedge clk);
        check("bp_stall", fsm_state, 2'd2);
        check("bp_no_load", ram_load0, 1'b0);
        check("bp_hold_d0", rsp_data0, 16'hBEEF);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk); check("bp_r1", {rsp_valid, rsp_data0, rsp_data1}, {1'b1, 16'hBEEF, 16'h0000});
        @(negedge clk); check("bp_r2", {rsp_valid, rsp_data0, rsp_data1}, {1'b1, 16'h1111, 16'h2222});
        @(negedge clk); check("bp_r3", {rsp_valid, rsp_data0, rsp_data1}, {1'b1, 16'h2222, 16'h1111});
        @(negedge clk); check("bp_r4", {rsp_valid, rsp_data0, rsp_data1}, {1'b1, 16'h0000, 16'hBEEF});
        @(negedge clk); check("bp_done", rsp_valid, 1'b0);

        // Full queue: stalled read at the head, three writes behind it
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        enq(1'b0, 16'd5, 16'd6, 16'd0);
        enq(1'b0, 16'd7, 16'd8, 16'd0);
        enq(1'b1, 16'd20, 16'd0, 16'hAAAA);
        enq(1'b1, 16'd21, 16'd0, 16'hBBBB);
        enq(1'b1, 16'd22, 16'd0, 16'hCCCC);
        @(negedge clk);
        check("full_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        enq(1'b1, 16'd23, 16'd0, 16'hDDDD);
        @(negedge clk);
        check("full_ready2", req_ready, 1'b0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        idle(8);
        check("full_wr_count", wr_count, 16'd6);
        enq(1'b0, 16'd20, 16'd21, 16'd0);
        expect_rsp("full_a", 16'hAAAA, 16'hBBBB);
        enq(1'b0, 16'd22, 16'd23, 16'd0);
        expect_rsp("full_b", 16'hCCCC, 16'h0000);
        check("full_rd_count", rd_count, 16'd9);
        idle(2);

        // Flush with a held response and two queued reads; enqueue on the flush edge drops
        rsp_ready = 1'b0;
        enq(1'b0, 16'd20, 16'd22, 16'd0);
        enq(1'b0, 16'd21, 16'd21, 16'd0);
        enq(1'b0, 16'd22, 16'd22, 16'd0);
        flush = 1'b1;
        req_write = 1'b1; req_addr0 = 16'd30; req_wdata = 16'hEEEE; req_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("fl_idle", fsm_state, 2'd0);
        check("fl_ready", req_ready, 1'b1);
        check("fl_rsp", {rsp_valid, rsp_data0, rsp_data1}, {1'b1, 16'hAAAA, 16'hCCCC});
        check("fl_rd_count", rd_count, 16'd10);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        idle(4);
        check("fl_rd_count2", rd_count, 16'd10);
        enq(1'b0, 16'd30, 16'd30, 16'd0);
        expect_rsp("fl_dropped", 16'h0000, 16'h0000);
        check("fl_wr_count", wr_count, 16'd6);

        // Counter wrap on the 2-bit instance
        s_req_valid = 1'b1;
        idle(5);
        s_req_valid = 1'b0;
        idle(4);
        @(negedge clk);
        check("wrap_wr_count", s_wr_count, 2'd1);
        check("wrap_rd_count", s_rd_count, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
